// File: rtl/pipe_fetch.sv
// pipe_fetch: Y86-64 fetch stage together with the F and D pipeline registers.
//
// The fetch PC is chosen from the mispredicted-branch repair value, the ret
// return address, or the predicted PC. Instruction bytes come from an internal
// byte-addressed memory that is written by a loader port. The fetched fields,
// status and fall-through PC are registered into the D bank under the control
// unit's stall/bubble signals.
//
// Ports:
//   clk, reset              single clock, synchronous active-high reset
//   F_stall                 hold the predicted-PC register
//   D_stall, D_bubble       hold D / load a nop bubble into D (stall wins)
//   M_icode, M_Cnd, M_valA  memory-stage repair of a not-taken jXX
//   W_icode, W_valM         write-back-stage repair for ret
//   imem_we/waddr/wdata     instruction memory byte loader
//   F_predPC                predicted PC register
//   f_pc                    selected fetch PC (combinational)
//   D_*                     decode-stage register bank outputs
module pipe_fetch #(
    parameter int MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic [3:0]  M_icode,
    input  logic        M_Cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    input  logic        imem_we,
    input  logic [63:0] imem_waddr,
    input  logic [7:0]  imem_wdata,
    output logic [63:0] F_predPC,
    output logic [63:0] f_pc,
    output logic [3:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP
);

    localparam int          AW        = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [64:0] MEM_LIMIT = 65'(MEM_SIZE);

    localparam logic [3:0] STAT_AOK = 4'b1000;
    localparam logic [3:0] STAT_HLT = 4'b0100;
    localparam logic [3:0] STAT_ADR = 4'b0010;
    localparam logic [3:0] STAT_INS = 4'b0001;

    logic [7:0] mem [MEM_SIZE];

    logic [3:0]  f_icode;
    logic [3:0]  f_ifun;
    logic [3:0]  f_rA;
    logic [3:0]  f_rB;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic [3:0]  f_stat;
    logic [63:0] f_pred;

    // Addresses are carried in 65 bits so that reads near the top of the
    // 64-bit space never wrap back into valid memory.
    function automatic logic [7:0] rd(input logic [64:0] addr);
        if (addr < MEM_LIMIT) begin
            rd = mem[addr[AW-1:0]];
        end else begin
            rd = 8'h00;
        end
    endfunction

    // Loader write port; out-of-range addresses are dropped rather than aliased.
    always_ff @(posedge clk) begin
        if (imem_we && ({1'b0, imem_waddr} < MEM_LIMIT)) begin
            mem[imem_waddr[AW-1:0]] <= imem_wdata;
        end
    end

    // Branch repair takes precedence over ret repair.
    always_comb begin
        if (M_icode == 4'h7 && !M_Cnd) begin
            f_pc = M_valA;
        end else if (W_icode == 4'h9) begin
            f_pc = W_valM;
        end else begin
            f_pc = F_predPC;
        end
    end

    // Instruction decode for the fetch stage: field extraction, length,
    // memory-range check, status and next-PC prediction.
    always_comb begin
        logic [64:0] pc65;
        logic [7:0]  byte0;
        logic [7:0]  byte1;
        logic [3:0]  raw_icode;
        logic        need_regids;
        logic        need_valC;
        logic [3:0]  len;
        logic [64:0] valc_base;
        logic        imem_error;

        pc65        = {1'b0, f_pc};
        byte0       = rd(pc65);
        byte1       = rd(pc65 + 65'd1);
        raw_icode   = byte0[7:4];
        need_regids = (raw_icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
        need_valC   = (raw_icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8});
        len         = 4'd1 + {3'b000, need_regids} + (need_valC ? 4'd8 : 4'd0);
        imem_error  = (pc65 >= MEM_LIMIT) || ((pc65 + 65'(len)) > MEM_LIMIT);
        valc_base   = pc65 + (need_regids ? 65'd2 : 65'd1);

        f_icode = raw_icode;
        f_ifun  = byte0[3:0];
        f_rA    = need_regids ? byte1[7:4] : 4'hF;
        f_rB    = need_regids ? byte1[3:0] : 4'hF;
        f_valC  = 64'h0;
        if (need_valC) begin
            for (int k = 0; k < 8; k++) begin
                f_valC[8*k +: 8] = rd(valc_base + 65'(k));
            end
        end
        f_valP = f_pc + 64'(len);

        // A fetch that runs off the end of memory becomes a nop carrying ADR.
        if (imem_error) begin
            f_icode = 4'h1;
            f_ifun  = 4'h0;
            f_rA    = 4'hF;
            f_rB    = 4'hF;
            f_valC  = 64'h0;
        end

        if (imem_error) begin
            f_stat = STAT_ADR;
        end else if (f_icode > 4'hB) begin
            f_stat = STAT_INS;
        end else if (f_icode == 4'h0) begin
            f_stat = STAT_HLT;
        end else begin
            f_stat = STAT_AOK;
        end

        // jXX is predicted taken; call always goes to its target.
        f_pred = (f_icode == 4'h7 || f_icode == 4'h8) ? f_valC : f_valP;
    end

    // Predicted-PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            F_predPC <= 64'h0;
        end else if (!F_stall) begin
            F_predPC <= f_pred;
        end
    end

    // Decode register bank; a stall holds even when a bubble is also requested.
    always_ff @(posedge clk) begin
        if (reset || (!D_stall && D_bubble)) begin
            D_stat  <= STAT_AOK;
            D_icode <= 4'h1;
            D_ifun  <= 4'h0;
            D_rA    <= 4'hF;
            D_rB    <= 4'hF;
            D_valC  <= 64'h0;
            D_valP  <= 64'h0;
        end else if (!D_stall) begin
            D_stat  <= f_stat;
            D_icode <= f_icode;
            D_ifun  <= f_ifun;
            D_rA    <= f_rA;
            D_rB    <= f_rB;
            D_valC  <= f_valC;
            D_valP  <= f_valP;
        end
    end

endmodule
